// File: rtl/div_iter_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and the RV64 *W forms.
// Operands are reduced to magnitudes at accept and the signs are fixed up in a single FIX cycle.
module div_iter_unit #(
    parameter int unsigned XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_div_valid,
    output logic            o_div_ready,
    input  logic [1:0]      i_div_op,
    input  logic            i_div_word,
    input  logic [XLEN-1:0] i_op0,
    input  logic [XLEN-1:0] i_op1,
    input  logic            i_div_flush,
    output logic            o_div_busy,
    output logic            o_res_valid,
    output logic [XLEN-1:0] o_res
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    localparam logic [6:0] CntFull = 7'(XLEN - 1);
    localparam logic [6:0] CntWord = 7'd31;

    // Bits above 31 take the supplied extension bit.
    function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v, input logic s);
        logic [XLEN-1:0] o;
        for (int i = 0; i < XLEN; i++) begin
            o[i] = (i < 32) ? v[i] : s;
        end
        return o;
    endfunction

    function automatic logic [XLEN-1:0] fin(input logic [XLEN-1:0] v, input logic word);
        return word ? ext32(v, v[31]) : v;
    endfunction

    state_e          r_state;
    logic [1:0]      r_op;
    logic            r_word;
    logic            r_qneg;
    logic            r_rneg;
    logic [6:0]      r_cnt;
    logic [XLEN-1:0] r_div;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_res;

    logic            w_word;
    logic            w_signed;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic            w_s0;
    logic            w_s1;
    logic [XLEN-1:0] w_ma;
    logic [XLEN-1:0] w_mb;
    logic [XLEN-1:0] w_min;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN-1:0] w_spec_res;
    logic            w_accept;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_trial;
    logic            w_ge;
    logic [XLEN-1:0] w_fq;
    logic [XLEN-1:0] w_fr;
    logic [XLEN-1:0] w_fix_res;

    always_comb begin
        w_word   = (XLEN > 32) && i_div_word;
        w_signed = ~i_div_op[0];
        w_a      = w_word ? ext32(i_op0, w_signed & i_op0[31]) : i_op0;
        w_b      = w_word ? ext32(i_op1, w_signed & i_op1[31]) : i_op1;
        w_s0     = w_signed & w_a[XLEN-1];
        w_s1     = w_signed & w_b[XLEN-1];
        w_ma     = w_s0 ? -w_a : w_a;
        w_mb     = w_s1 ? -w_b : w_b;
        w_min    = w_word ? ext32(XLEN'(32'h8000_0000), 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
        w_div0   = (w_b == '0);
        w_ovf    = w_signed && (w_a == w_min) && (w_b == '1);
        if (w_div0) begin
            w_spec_res = fin(i_div_op[1] ? w_a : '1, w_word);
        end else begin
            w_spec_res = fin(i_div_op[1] ? '0 : w_a, w_word);
        end
        w_accept = i_div_valid && (r_state == StIdle);
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        w_shift   = {r_rem, r_quo[XLEN-1]};
        w_ge      = (w_shift >= {1'b0, r_div});
        w_trial   = w_shift - {1'b0, r_div};
        w_fq      = r_qneg ? -r_quo : r_quo;
        w_fr      = r_rneg ? -r_rem : r_rem;
        w_fix_res = fin(r_op[1] ? w_fr : w_fq, r_word);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_op    <= '0;
            r_word  <= 1'b0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_cnt   <= '0;
            r_div   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_res   <= '0;
        end else if (i_div_flush) begin
            r_state <= StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_op   <= i_div_op;
                        r_word <= w_word;
                        r_qneg <= w_s0 ^ w_s1;
                        r_rneg <= w_s0;
                        r_div  <= w_mb;
                        r_rem  <= '0;
                        // Word forms place the 32-bit dividend at the top so N=32 steps suffice.
                        r_quo  <= w_word ? (w_ma << (XLEN - 32)) : w_ma;
                        r_cnt  <= w_word ? CntWord : CntFull;
                        if (w_div0 || w_ovf) begin
                            r_res   <= w_spec_res;
                            r_state <= StDone;
                        end else begin
                            r_state <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    r_rem <= w_ge ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
                    r_quo <= {r_quo[XLEN-2:0], w_ge};
                    if (r_cnt == '0) begin
                        r_state <= StFix;
                    end else begin
                        r_cnt <= r_cnt - 7'd1;
                    end
                end
                StFix: begin
                    r_res   <= w_fix_res;
                    r_state <= StDone;
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_div_ready = (r_state == StIdle);
    assign o_div_busy  = (r_state == StCalc) || (r_state == StFix);
    assign o_res_valid = (r_state == StDone);
    assign o_res       = r_res;

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed bench for div_iter_unit: a table of hand-computed vectors plus flush/reset sequences.
module tb_div_iter_unit;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        div_valid;
    logic        div_ready;
    logic [1:0]  div_op;
    logic        div_word;
    logic [63:0] op0;
    logic [63:0] op1;
    logic        div_flush;
    logic        div_busy;
    logic        res_valid;
    logic [63:0] res;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_iter_unit #(.XLEN(64)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_div_valid (div_valid),
        .o_div_ready (div_ready),
        .i_div_op    (div_op),
        .i_div_word  (div_word),
        .i_op0       (op0),
        .i_op1       (op1),
        .i_div_flush (div_flush),
        .o_div_busy  (div_busy),
        .o_res_valid (res_valid),
        .o_res       (res)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one request and wait (bounded) for its result; lat counts edges from the request cycle.
    task automatic run_op(input logic [1:0] op, input logic word, input logic [63:0] a,
                          input logic [63:0] b, input logic hold, output logic [63:0] r,
                          output int lat);
        @(negedge clk);
        div_op = op; div_word = word; op0 = a; op1 = b; div_valid = 1'b1;
        @(posedge clk); #1;
        if (!hold) begin
            div_valid = 1'b0;
            op0 = '0; op1 = '0;
        end
        lat = 1;
        while (!res_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        r = res;
    endtask

    vec_t vecs[21];
    logic [63:0] r;
    int lat;
    int pulses;

    initial begin
        vecs[0]  = '{"divu_100_7",   2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 66};
        vecs[1]  = '{"remu_100_7",   2'b11, 1'b0, 64'd100, 64'd7, 64'd2, 66};
        vecs[2]  = '{"div_m20_3",    2'b00, 1'b0, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 66};
        vecs[3]  = '{"rem_m20_3",    2'b10, 1'b0, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 66};
        vecs[4]  = '{"rem_20_m3",    2'b10, 1'b0, 64'd20, -64'sd3, 64'd2, 66};
        vecs[5]  = '{"div_20_m3",    2'b00, 1'b0, 64'd20, -64'sd3, 64'hFFFF_FFFF_FFFF_FFFA, 66};
        vecs[6]  = '{"div_m7_m2",    2'b00, 1'b0, -64'sd7, -64'sd2, 64'd3, 66};
        vecs[7]  = '{"rem_m7_m2",    2'b10, 1'b0, -64'sd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFF, 66};
        vecs[8]  = '{"divu_by0",     2'b01, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        vecs[9]  = '{"remu_by0",     2'b11, 1'b0, 64'd5, 64'd0, 64'd5, 1};
        vecs[10] = '{"div_ovf",      2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'h8000_0000_0000_0000, 1};
        vecs[11] = '{"rem_ovf",      2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'd0, 1};
        vecs[12] = '{"divw",         2'b00, 1'b1, 64'h0000_0001_FFFF_FFF0, 64'd2,
                     64'hFFFF_FFFF_FFFF_FFF8, 34};
        vecs[13] = '{"remuw",        2'b11, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10, 64'hF, 34};
        vecs[14] = '{"divuw_max_1",  2'b01, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1,
                     64'hFFFF_FFFF_FFFF_FFFF, 34};
        vecs[15] = '{"remw_by0",     2'b10, 1'b1, 64'h0000_0000_8000_0000, 64'd0,
                     64'hFFFF_FFFF_8000_0000, 1};
        vecs[16] = '{"divw_ovf",     2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
                     64'hFFFF_FFFF_8000_0000, 1};
        vecs[17] = '{"divu_big",     2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10,
                     64'h0FFF_FFFF_FFFF_FFFF, 66};
        vecs[18] = '{"remu_big",     2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF, 66};
        vecs[19] = '{"divw_m7_2",    2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                     64'hFFFF_FFFF_FFFF_FFFD, 34};
        vecs[20] = '{"remw_m7_2",    2'b10, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                     64'hFFFF_FFFF_FFFF_FFFF, 34};

        rst_n = 1'b0; div_valid = 1'b0; div_op = '0; div_word = 1'b0;
        op0 = '0; op1 = '0; div_flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_res", res, 64'd0);
        chk("reset_res_valid", {63'd0, res_valid}, 64'd0);
        chk("reset_ready", {63'd0, div_ready}, 64'd1);
        chk("reset_busy", {63'd0, div_busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            run_op(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b, 1'b0, r, lat);
            chk({vecs[i].name, "_res"}, r, vecs[i].exp);
            chk({vecs[i].name, "_lat"}, 64'(lat), 64'(vecs[i].lat));
            @(posedge clk); #1;
            chk({vecs[i].name, "_pulse_end"}, {62'd0, res_valid, div_ready}, 64'b01);
        end

        // Flush at CALC cycle 10 kills the op silently.
        @(negedge clk);
        div_op = 2'b01; div_word = 1'b0; op0 = 64'd100; op1 = 64'd7; div_valid = 1'b1;
        @(posedge clk); #1;
        div_valid = 1'b0;
        chk("flush_busy", {62'd0, div_busy, div_ready}, 64'b10);
        repeat (9) @(posedge clk);
        @(negedge clk);
        div_flush = 1'b1;
        @(posedge clk); #1;
        div_flush = 1'b0;
        chk("flush_ready", {62'd0, div_ready, res_valid}, 64'b10);
        pulses = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (res_valid) pulses++;
        end
        chk("flush_no_pulse", 64'(pulses), 64'd0);
        run_op(2'b01, 1'b0, 64'd9, 64'd3, 1'b0, r, lat);
        chk("after_flush_res", r, 64'd3);
        chk("after_flush_lat", 64'(lat), 64'd66);
        @(posedge clk); #1;

        // Flush with a request in IDLE drops it; a divide-by-zero would otherwise pulse at once.
        @(negedge clk);
        div_op = 2'b01; op0 = 64'd5; op1 = 64'd0; div_valid = 1'b1; div_flush = 1'b1;
        @(posedge clk); #1;
        div_valid = 1'b0; div_flush = 1'b0;
        chk("idle_flush_ready", {62'd0, div_ready, res_valid}, 64'b10);
        @(posedge clk); #1;
        chk("idle_flush_no_pulse", {63'd0, res_valid}, 64'd0);

        // Reset mid-CALC with a request held high.
        @(negedge clk);
        div_op = 2'b01; op0 = 64'd100; op1 = 64'd7; div_valid = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_res", res, 64'd0);
        chk("midrst_state", {61'd0, res_valid, div_ready, div_busy}, 64'b010);
        div_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Request held through the busy period is accepted exactly once.
        run_op(2'b01, 1'b0, 64'd100, 64'd7, 1'b1, r, lat);
        @(negedge clk);
        div_valid = 1'b0;
        chk("held_res", r, 64'd14);
        chk("held_lat", 64'(lat), 64'd66);
        pulses = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (res_valid) pulses++;
        end
        chk("held_single_pulse", 64'(pulses), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
